// File: rtl/bsg_circular_ptr_ckpt_pkg.sv
// Width helpers shared by the checkpointed circular pointer and its step unit.
package bsg_circular_ptr_ckpt_pkg;

   // clog2 that never returns 0, so a single-value field still gets one bit
   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_circular_ptr_step.sv
// Steps a linear index L in [0, 2*slots_p) by +add-sub modulo 2*slots_p,
// and reports whether the step moved L into the other phase half.
module bsg_circular_ptr_step
   import bsg_circular_ptr_ckpt_pkg::*;
#(
   parameter int  slots_p      = 1,
   parameter int  max_add_p    = 1,
   parameter int  max_sub_p    = 1,
   localparam int l_width_lp   = $clog2(2*slots_p),
   localparam int add_width_lp = $clog2(max_add_p+1),
   localparam int sub_width_lp = safe_clog2(max_sub_p+1)
) (
   input  logic [l_width_lp-1:0]   l_i,
   input  logic [add_width_lp-1:0] add_i,
   input  logic [sub_width_lp-1:0] sub_i,
   output logic [l_width_lp-1:0]   l_next_o,
   output logic                    wrap_o
);

   // Two guard bits: one for sums up to 3*slots_p, one for the sign
   localparam int                    w_lp       = l_width_lp + 2;
   localparam logic [l_width_lp-1:0] slots_l_lp = l_width_lp'(slots_p);

   logic [w_lp-1:0] w_add;
   logic [w_lp-1:0] w_sub;

   assign w_add = w_lp'(add_i);
   assign w_sub = (max_sub_p == 0) ? '0 : w_lp'(sub_i);

   generate
      if (((2*slots_p) & (2*slots_p - 1)) == 0) begin : g_pow2
         assign l_next_o = l_i + l_width_lp'(w_add) - l_width_lp'(w_sub);
      end else begin : g_mod
         localparam logic [w_lp-1:0] mod_lp = w_lp'(2*slots_p);

         logic [w_lp-1:0] w_sum;
         logic [w_lp-1:0] w_sum_up;
         logic [w_lp-1:0] w_sum_dn;
         logic [w_lp-1:0] w_sel;

         assign w_sum    = w_lp'(l_i) + w_add - w_sub;
         assign w_sum_up = w_sum + mod_lp;
         assign w_sum_dn = w_sum - mod_lp;

         // Underflow if the raw sum is negative, overflow if sum-mod is not
         always_comb begin
            if (w_sum[w_lp-1])         w_sel = w_sum_up;
            else if (!w_sum_dn[w_lp-1]) w_sel = w_sum_dn;
            else                       w_sel = w_sum;
         end

         assign l_next_o = l_width_lp'(w_sel);
      end
   endgenerate

   assign wrap_o = (l_next_o >= slots_l_lp) != (l_i >= slots_l_lp);

endmodule

// File: rtl/bsg_circular_ptr_ckpt.sv
// Circular pointer with wrap phase, bidirectional step, one checkpoint/restore
// register, and a count of slots advanced since the checkpoint.
module bsg_circular_ptr_ckpt
   import bsg_circular_ptr_ckpt_pkg::*;
#(
   parameter int  slots_p        = 1,
   parameter int  max_add_p      = 1,
   parameter int  max_sub_p      = 1,
   localparam int ptr_width_lp   = safe_clog2(slots_p),
   localparam int count_width_lp = $clog2(slots_p+1),
   localparam int add_width_lp   = $clog2(max_add_p+1),
   localparam int sub_width_lp   = safe_clog2(max_sub_p+1)
) (
   input  logic                      clk,
   input  logic                      reset_i,
   input  logic [add_width_lp-1:0]   add_i,
   input  logic [sub_width_lp-1:0]   sub_i,
   input  logic                      ckpt_i,
   input  logic                      restore_i,
   output logic [ptr_width_lp-1:0]   o,
   output logic                      phase_o,
   output logic [ptr_width_lp-1:0]   n_o,
   output logic                      n_phase_o,
   output logic                      wrap_o,
   output logic [ptr_width_lp-1:0]   ckpt_o,
   output logic                      ckpt_phase_o,
   output logic [count_width_lp-1:0] spec_count_o
);

   localparam int                    l_width_lp = $clog2(2*slots_p);
   localparam logic [l_width_lp-1:0] slots_l_lp = l_width_lp'(slots_p);

   logic [ptr_width_lp-1:0] r_ptr;
   logic                    r_phase;
   logic [ptr_width_lp-1:0] r_ckpt_ptr;
   logic                    r_ckpt_phase;

   logic [l_width_lp-1:0]   w_l;
   logic [l_width_lp-1:0]   w_l_ckpt;
   logic [l_width_lp-1:0]   w_l_step;
   logic [l_width_lp-1:0]   w_l_next;
   logic [l_width_lp-1:0]   w_l_next_lo;
   logic [l_width_lp-1:0]   w_l_cnt;
   logic                    w_step_wrap;
   logic                    w_unused_cnt_wrap;

   assign w_l      = r_phase      ? l_width_lp'(r_ptr) + slots_l_lp      : l_width_lp'(r_ptr);
   assign w_l_ckpt = r_ckpt_phase ? l_width_lp'(r_ckpt_ptr) + slots_l_lp : l_width_lp'(r_ckpt_ptr);

   bsg_circular_ptr_step #(
      .slots_p   (slots_p),
      .max_add_p (max_add_p),
      .max_sub_p (max_sub_p)
   ) u_step (
      .l_i      (w_l),
      .add_i    (add_i),
      .sub_i    (sub_i),
      .l_next_o (w_l_step),
      .wrap_o   (w_step_wrap)
   );

   // Same modular subtractor, widened so the whole checkpoint index is the rewind
   bsg_circular_ptr_step #(
      .slots_p   (slots_p),
      .max_add_p (1),
      .max_sub_p (2*slots_p - 1)
   ) u_count (
      .l_i      (w_l),
      .add_i    (1'b0),
      .sub_i    (w_l_ckpt),
      .l_next_o (w_l_cnt),
      .wrap_o   (w_unused_cnt_wrap)
   );

   assign w_l_next     = restore_i ? w_l_ckpt : w_l_step;
   assign n_phase_o    = (w_l_next >= slots_l_lp);
   assign w_l_next_lo  = n_phase_o ? w_l_next - slots_l_lp : w_l_next;
   assign n_o          = ptr_width_lp'(w_l_next_lo);
   assign wrap_o       = ~restore_i & w_step_wrap;

   assign o            = r_ptr;
   assign phase_o      = r_phase;
   assign ckpt_o       = r_ckpt_ptr;
   assign ckpt_phase_o = r_ckpt_phase;
   assign spec_count_o = count_width_lp'(w_l_cnt);

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values; blocking here would let r_ckpt see a half-updated pointer.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_ptr        <= '0;
         r_phase      <= 1'b0;
         r_ckpt_ptr   <= '0;
         r_ckpt_phase <= 1'b0;
      end else begin
         r_ptr   <= n_o;
         r_phase <= n_phase_o;
         if (ckpt_i) begin
            r_ckpt_ptr   <= n_o;
            r_ckpt_phase <= n_phase_o;
         end
      end
   end

`ifndef BSG_HIDE_FROM_SYNTHESIS
   localparam int cw_lp = l_width_lp + 2;

   // Speculative distance is only meaningful once a checkpoint exists
   logic r_ckpt_valid;

   always_ff @(posedge clk) begin
      if (reset_i)     r_ckpt_valid <= 1'b0;
      else if (ckpt_i) r_ckpt_valid <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_i) begin
         assert (add_i <= add_width_lp'(max_add_p));
         assert (max_sub_p == 0 || sub_i <= sub_width_lp'(max_sub_p));
         if (r_ckpt_valid) begin
            assert (w_l_cnt <= slots_l_lp);
            assert (restore_i || max_sub_p == 0 ||
                    cw_lp'(w_l_cnt) + cw_lp'(add_i) >= cw_lp'(sub_i));
         end
      end
   end
`endif

endmodule

// File: tb/tb_bsg_circular_ptr_ckpt.sv
// Bench for bsg_circular_ptr_ckpt: three configurations driven from one
// linear-index reference model, with directed scenarios and a random soak.
module tb_bsg_circular_ptr_ckpt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_i;

   // A: slots 5, add<=3, sub<=2
   logic [1:0] a_add, a_sub;
   logic       a_ck, a_rs;
   logic [2:0] a_o, a_n, a_ckpt, a_cnt;
   logic       a_ph, a_nph, a_wrap, a_ckph;
   // B: slots 4, add<=4, sub<=1 (power-of-two modulus)
   logic [2:0] b_add;
   logic [0:0] b_sub;
   logic       b_ck, b_rs;
   logic [1:0] b_o, b_n, b_ckpt;
   logic [2:0] b_cnt;
   logic       b_ph, b_nph, b_wrap, b_ckph;
   // C: slots 1, add<=1, no rewind path
   logic [0:0] c_add, c_sub;
   logic       c_ck, c_rs;
   logic [0:0] c_o, c_n, c_ckpt, c_cnt;
   logic       c_ph, c_nph, c_wrap, c_ckph;

   bsg_circular_ptr_ckpt #(.slots_p(5), .max_add_p(3), .max_sub_p(2)) u_a (
      .clk(clk), .reset_i(reset_i), .add_i(a_add), .sub_i(a_sub), .ckpt_i(a_ck),
      .restore_i(a_rs), .o(a_o), .phase_o(a_ph), .n_o(a_n), .n_phase_o(a_nph),
      .wrap_o(a_wrap), .ckpt_o(a_ckpt), .ckpt_phase_o(a_ckph), .spec_count_o(a_cnt));

   bsg_circular_ptr_ckpt #(.slots_p(4), .max_add_p(4), .max_sub_p(1)) u_b (
      .clk(clk), .reset_i(reset_i), .add_i(b_add), .sub_i(b_sub), .ckpt_i(b_ck),
      .restore_i(b_rs), .o(b_o), .phase_o(b_ph), .n_o(b_n), .n_phase_o(b_nph),
      .wrap_o(b_wrap), .ckpt_o(b_ckpt), .ckpt_phase_o(b_ckph), .spec_count_o(b_cnt));

   bsg_circular_ptr_ckpt #(.slots_p(1), .max_add_p(1), .max_sub_p(0)) u_c (
      .clk(clk), .reset_i(reset_i), .add_i(c_add), .sub_i(c_sub), .ckpt_i(c_ck),
      .restore_i(c_rs), .o(c_o), .phase_o(c_ph), .n_o(c_n), .n_phase_o(c_nph),
      .wrap_o(c_wrap), .ckpt_o(c_ckpt), .ckpt_phase_o(c_ckph), .spec_count_o(c_cnt));

   int n_checks = 0;
   int n_errors = 0;

   int sl[3]  = '{5, 4, 1};
   int ma[3]  = '{3, 4, 1};
   int ms[3]  = '{2, 1, 0};
   int cwd[3] = '{3, 3, 1};

   // Reference state: linear index of pointer and checkpoint
   int m_l[3], m_ck[3];
   bit m_valid[3];

   int in_add[3], in_sub[3];
   bit in_ck[3], in_rs[3];
   int last_wrap[3];

   int ob_o[3], ob_ph[3], ob_n[3], ob_nph[3], ob_wrap[3], ob_ck[3], ob_ckph[3], ob_cnt[3];

   always_comb begin
      ob_o[0] = int'(a_o);   ob_ph[0] = int'(a_ph);   ob_n[0] = int'(a_n);   ob_nph[0] = int'(a_nph);
      ob_wrap[0] = int'(a_wrap); ob_ck[0] = int'(a_ckpt); ob_ckph[0] = int'(a_ckph); ob_cnt[0] = int'(a_cnt);
      ob_o[1] = int'(b_o);   ob_ph[1] = int'(b_ph);   ob_n[1] = int'(b_n);   ob_nph[1] = int'(b_nph);
      ob_wrap[1] = int'(b_wrap); ob_ck[1] = int'(b_ckpt); ob_ckph[1] = int'(b_ckph); ob_cnt[1] = int'(b_cnt);
      ob_o[2] = int'(c_o);   ob_ph[2] = int'(c_ph);   ob_n[2] = int'(c_n);   ob_nph[2] = int'(c_nph);
      ob_wrap[2] = int'(c_wrap); ob_ck[2] = int'(c_ckpt); ob_ckph[2] = int'(c_ckph); ob_cnt[2] = int'(c_cnt);
   end

   function automatic int m_next(int d);
      int m = 2 * sl[d];
      int s = (ms[d] == 0) ? 0 : in_sub[d];
      if (in_rs[d]) return m_ck[d];
      return ((m_l[d] + in_add[d] - s) % m + m) % m;
   endfunction

   function automatic int m_count(int d);
      int m = 2 * sl[d];
      return ((m_l[d] - m_ck[d]) % m + m) % m;
   endfunction

   task automatic drive();
      a_add = 2'(in_add[0]); a_sub = 2'(in_sub[0]); a_ck = in_ck[0]; a_rs = in_rs[0];
      b_add = 3'(in_add[1]); b_sub = 1'(in_sub[1]); b_ck = in_ck[1]; b_rs = in_rs[1];
      c_add = 1'(in_add[2]); c_sub = 1'(in_sub[2]); c_ck = in_ck[2]; c_rs = in_rs[2];
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 3; d++) begin
         in_add[d] = 0; in_sub[d] = 0; in_ck[d] = 1'b0; in_rs[d] = 1'b0;
      end
   endtask

   // One clock on all three DUTs, checked against the model before and after the edge
   task automatic step(input bit rst);
      int nl[3];
      int exp_v;
      reset_i = rst;
      drive();
      #1;
      for (int d = 0; d < 3; d++) begin
         nl[d] = m_next(d);
         n_checks += 3;
         if (ob_n[d] !== nl[d] % sl[d]) begin
            n_errors++;
            $display("FAIL n_o dut%0d: got %0d expected %0d", d, ob_n[d], nl[d] % sl[d]);
         end
         if (ob_nph[d] !== nl[d] / sl[d]) begin
            n_errors++;
            $display("FAIL n_phase_o dut%0d: got %0d expected %0d", d, ob_nph[d], nl[d] / sl[d]);
         end
         exp_v = (!in_rs[d] && (nl[d] / sl[d] != m_l[d] / sl[d])) ? 1 : 0;
         if (ob_wrap[d] !== exp_v) begin
            n_errors++;
            $display("FAIL wrap_o dut%0d: got %0d expected %0d", d, ob_wrap[d], exp_v);
         end
         last_wrap[d] = ob_wrap[d];
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_l[d] = 0; m_ck[d] = 0; m_valid[d] = 1'b0;
         end else begin
            if (in_ck[d]) begin
               m_ck[d] = nl[d]; m_valid[d] = 1'b1;
            end
            m_l[d] = nl[d];
         end
         n_checks += 5;
         if (ob_o[d] !== m_l[d] % sl[d]) begin
            n_errors++;
            $display("FAIL o dut%0d: got %0d expected %0d", d, ob_o[d], m_l[d] % sl[d]);
         end
         if (ob_ph[d] !== m_l[d] / sl[d]) begin
            n_errors++;
            $display("FAIL phase_o dut%0d: got %0d expected %0d", d, ob_ph[d], m_l[d] / sl[d]);
         end
         if (ob_ck[d] !== m_ck[d] % sl[d]) begin
            n_errors++;
            $display("FAIL ckpt_o dut%0d: got %0d expected %0d", d, ob_ck[d], m_ck[d] % sl[d]);
         end
         if (ob_ckph[d] !== m_ck[d] / sl[d]) begin
            n_errors++;
            $display("FAIL ckpt_phase_o dut%0d: got %0d expected %0d", d, ob_ckph[d], m_ck[d] / sl[d]);
         end
         exp_v = m_count(d) % (1 << cwd[d]);
         if (ob_cnt[d] !== exp_v) begin
            n_errors++;
            $display("FAIL spec_count_o dut%0d: got %0d expected %0d", d, ob_cnt[d], exp_v);
         end
      end
      @(negedge clk);
      reset_i = 1'b0;
      clear_inputs();
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         in_add[d] = 1; in_ck[d] = 1'b1;
      end
      step(0);
      for (int d = 0; d < 3; d++) begin
         in_add[d] = 1; in_ck[d] = 1'b1;
      end
      step(1);
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (ob_o[d] !== 0 || ob_ph[d] !== 0 || ob_ck[d] !== 0 || ob_ckph[d] !== 0 || ob_cnt[d] !== 0) begin
            n_errors++;
            $display("FAIL reset_state dut%0d: got o=%0d ph=%0d ck=%0d ckph=%0d cnt=%0d expected all 0",
                     d, ob_o[d], ob_ph[d], ob_ck[d], ob_ckph[d], ob_cnt[d]);
         end
      end
   endtask

   task automatic test_advance();
      step(1);
      in_add[0] = 3; step(0);
      n_checks++;
      if (ob_o[0] !== 3 || ob_ph[0] !== 0) begin
         n_errors++;
         $display("FAIL adv_first: got o=%0d ph=%0d expected o=3 ph=0", ob_o[0], ob_ph[0]);
      end
      in_add[0] = 3; step(0);
      n_checks++;
      if (ob_o[0] !== 1 || ob_ph[0] !== 1 || last_wrap[0] !== 1) begin
         n_errors++;
         $display("FAIL adv_wrap: got o=%0d ph=%0d wrap=%0d expected o=1 ph=1 wrap=1", ob_o[0], ob_ph[0], last_wrap[0]);
      end
   endtask

   task automatic test_rewind();
      in_sub[0] = 2; step(0);
      n_checks++;
      if (ob_o[0] !== 4 || ob_ph[0] !== 0 || last_wrap[0] !== 1) begin
         n_errors++;
         $display("FAIL rewind_wrap: got o=%0d ph=%0d wrap=%0d expected o=4 ph=0 wrap=1", ob_o[0], ob_ph[0], last_wrap[0]);
      end
      step(0);
      n_checks++;
      if (ob_o[0] !== 4 || ob_ph[0] !== 0 || last_wrap[0] !== 0) begin
         n_errors++;
         $display("FAIL hold: got o=%0d ph=%0d wrap=%0d expected o=4 ph=0 wrap=0", ob_o[0], ob_ph[0], last_wrap[0]);
      end
   endtask

   task automatic test_checkpoint();
      step(1);
      in_add[0] = 2; step(0);
      in_add[0] = 1; in_ck[0] = 1'b1; step(0);
      n_checks++;
      if (ob_ck[0] !== 3 || ob_ckph[0] !== 0 || ob_cnt[0] !== 0) begin
         n_errors++;
         $display("FAIL ckpt_capture: got ck=%0d ckph=%0d cnt=%0d expected ck=3 ckph=0 cnt=0", ob_ck[0], ob_ckph[0], ob_cnt[0]);
      end
      in_add[0] = 3; step(0);
      in_add[0] = 2; step(0);
      n_checks++;
      if (ob_o[0] !== 3 || ob_ph[0] !== 1 || ob_cnt[0] !== 5) begin
         n_errors++;
         $display("FAIL spec_full: got o=%0d ph=%0d cnt=%0d expected o=3 ph=1 cnt=5", ob_o[0], ob_ph[0], ob_cnt[0]);
      end
      in_add[0] = 3; in_rs[0] = 1'b1; step(0);
      n_checks++;
      if (ob_o[0] !== 3 || ob_ph[0] !== 0 || ob_cnt[0] !== 0 || last_wrap[0] !== 0) begin
         n_errors++;
         $display("FAIL restore: got o=%0d ph=%0d cnt=%0d wrap=%0d expected o=3 ph=0 cnt=0 wrap=0",
                  ob_o[0], ob_ph[0], ob_cnt[0], last_wrap[0]);
      end
   endtask

   task automatic test_net_step();
      step(1);
      repeat (3) begin
         in_add[0] = 3; step(0);
      end
      in_add[0] = 3; in_sub[0] = 2; in_ck[0] = 1'b1; step(0);
      n_checks++;
      if (ob_o[0] !== 0 || ob_ph[0] !== 0 || last_wrap[0] !== 1 || ob_ck[0] !== 0 || ob_ckph[0] !== 0) begin
         n_errors++;
         $display("FAIL net_step: got o=%0d ph=%0d wrap=%0d ck=%0d ckph=%0d expected 0 0 1 0 0",
                  ob_o[0], ob_ph[0], last_wrap[0], ob_ck[0], ob_ckph[0]);
      end
   endtask

   task automatic test_ckpt_restore();
      in_add[0] = 2; in_ck[0] = 1'b1; step(0);
      in_add[0] = 3; step(0);
      in_add[0] = 3; in_ck[0] = 1'b1; in_rs[0] = 1'b1; step(0);
      n_checks++;
      if (ob_o[0] !== 2 || ob_ph[0] !== 0 || ob_ck[0] !== 2 || ob_ckph[0] !== 0 || ob_cnt[0] !== 0) begin
         n_errors++;
         $display("FAIL ckpt_and_restore: got o=%0d ph=%0d ck=%0d ckph=%0d cnt=%0d expected 2 0 2 0 0",
                  ob_o[0], ob_ph[0], ob_ck[0], ob_ckph[0], ob_cnt[0]);
      end
      in_add[0] = 2; step(0);
      in_add[0] = 1; in_ck[0] = 1'b1; step(1);
      n_checks++;
      if (ob_o[0] !== 0 || ob_ph[0] !== 0 || ob_ck[0] !== 0 || ob_ckph[0] !== 0 || ob_cnt[0] !== 0) begin
         n_errors++;
         $display("FAIL reset_with_ckpt: got o=%0d ph=%0d ck=%0d ckph=%0d cnt=%0d expected all 0",
                  ob_o[0], ob_ph[0], ob_ck[0], ob_ckph[0], ob_cnt[0]);
      end
   endtask

   task automatic test_pow2();
      step(1);
      in_add[1] = 4; step(0);
      n_checks++;
      if (ob_o[1] !== 0 || ob_ph[1] !== 1 || last_wrap[1] !== 1) begin
         n_errors++;
         $display("FAIL pow2_first: got o=%0d ph=%0d wrap=%0d expected o=0 ph=1 wrap=1", ob_o[1], ob_ph[1], last_wrap[1]);
      end
      in_add[1] = 4; step(0);
      n_checks++;
      if (ob_o[1] !== 0 || ob_ph[1] !== 0 || last_wrap[1] !== 1) begin
         n_errors++;
         $display("FAIL pow2_second: got o=%0d ph=%0d wrap=%0d expected o=0 ph=0 wrap=1", ob_o[1], ob_ph[1], last_wrap[1]);
      end
   endtask

   task automatic test_single_slot();
      step(1);
      in_add[2] = 1; step(0);
      n_checks++;
      if (ob_o[2] !== 0 || ob_ph[2] !== 1) begin
         n_errors++;
         $display("FAIL single_toggle: got o=%0d ph=%0d expected o=0 ph=1", ob_o[2], ob_ph[2]);
      end
      in_add[2] = 1; in_sub[2] = 1; step(0);
      n_checks++;
      if (ob_o[2] !== 0 || ob_ph[2] !== 0) begin
         n_errors++;
         $display("FAIL single_sub_ignored: got o=%0d ph=%0d expected o=0 ph=0", ob_o[2], ob_ph[2]);
      end
   endtask

   task automatic test_random();
      bit rst;
      int a, s, s_eff, c;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int d = 0; d < 3; d++) begin
            in_rs[d] = ($urandom_range(0, 9) == 0);
            in_ck[d] = ($urandom_range(0, 7) == 0);
            a = 0; s = 0;
            for (int t = 0; t < 8; t++) begin
               a = $urandom_range(0, ma[d]);
               s = (ms[d] == 0) ? $urandom_range(0, 1) : $urandom_range(0, ms[d]);
               s_eff = (ms[d] == 0) ? 0 : s;
               c = m_count(d) + a - s_eff;
               if (!m_valid[d] || in_rs[d] || (c >= 0 && c <= sl[d])) break;
               a = 0; s = 0;
            end
            in_add[d] = a;
            in_sub[d] = s;
         end
         step(rst);
      end
   endtask

   initial begin
      reset_i = 1'b1;
      clear_inputs();
      drive();
      for (int d = 0; d < 3; d++) begin
         m_l[d] = 0; m_ck[d] = 0; m_valid[d] = 1'b0; last_wrap[d] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      reset_i = 1'b0;

      test_reset();
      test_advance();
      test_rewind();
      test_checkpoint();
      test_net_step();
      test_ckpt_restore();
      test_pow2();
      test_single_slot();
      test_random();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
